// File: rtl/dispatch_stage_pkg.sv
// dispatch_stage_pkg: shared types and constants for the dispatch (issue) stage.
//   ROB entry type and null tag, slot state encoding, operand / CDB / slot payloads.
package dispatch_stage_pkg;

    localparam int unsigned ROB_W  = 6;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned OP_W   = 6;
    localparam int unsigned RD_W   = 6;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned STAT_W = 32;

    typedef logic [ROB_W-1:0] rob_entry_t;

    // MSB set marks "no ROB dependency"; real entries are 0..31.
    localparam rob_entry_t ENTRY_NULL = 6'b100000;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } slot_state_e;

    // Operand value plus the ROB tag it is still waiting on (ENTRY_NULL when ready).
    typedef struct packed {
        logic [XLEN-1:0] v;
        rob_entry_t      q;
    } operand_t;

    // One result broadcast bus (ALU CDB, LSB CDB or commit).
    typedef struct packed {
        logic            valid;
        rob_entry_t      entry;
        logic [XLEN-1:0] result;
    } cdb_t;

    // Non-operand contents of the issue slot.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [OP_W-1:0] op;
        logic [RD_W-1:0] rd;
        logic [XLEN-1:0] imm;
        logic            is_ls;
        rob_entry_t      entry;
    } slot_t;

endpackage

// File: rtl/dispatch_stage_if.sv
// dispatch_stage_if: all decoder, regfile, ROB, RS/LSB and CDB signals of the
// dispatch stage. The stage uses the slave modport; its environment the master.
// Optional DISPATCH_STATS_EN adds the three stall counters.
interface dispatch_stage_if;
    import dispatch_stage_pkg::*;

    logic                 rdy;
    logic                 rollback;
    // instruction queue / decoder
    logic                 iq_valid;
    logic [XLEN-1:0]      iq_pc;
    logic [OP_W-1:0]      dec_op;
    logic [RD_W-1:0]      dec_rd;
    logic [XLEN-1:0]      dec_imm;
    logic [REG_W-1:0]     dec_rs1;
    logic [REG_W-1:0]     dec_rs2;
    logic                 dec_is_ls;
    logic                 iq_pop;
    // regfile read
    logic [XLEN-1:0]      rf_Vj;
    rob_entry_t           rf_Qj;
    logic [XLEN-1:0]      rf_Vk;
    rob_entry_t           rf_Qk;
    // back-end status
    logic                 rob_full;
    rob_entry_t           rob_tail;
    logic                 rs_full;
    logic                 lsb_full;
    // result buses
    logic                 alu_broadcast;
    rob_entry_t           alu_entry;
    logic [XLEN-1:0]      alu_result;
    logic                 lsb_broadcast;
    rob_entry_t           lsb_entry;
    logic [XLEN-1:0]      lsb_result;
    logic                 rob_commit;
    rob_entry_t           rob_entry;
    logic [XLEN-1:0]      rob_result;
    // issue bus
    logic                 rs_get_instruction;
    logic                 lsb_get_instruction;
    logic                 rob_alloc;
    logic                 rename_en;
    logic [XLEN-1:0]      pc_out;
    logic [OP_W-1:0]      op_out;
    logic [RD_W-1:0]      rd_out;
    logic [XLEN-1:0]      imm_out;
    rob_entry_t           entry_out;
    logic [XLEN-1:0]      Vj_out;
    rob_entry_t           Qj_out;
    logic [XLEN-1:0]      Vk_out;
    rob_entry_t           Qk_out;
`ifdef DISPATCH_STATS_EN
    logic [STAT_W-1:0]    stall_rob_cnt;
    logic [STAT_W-1:0]    stall_rs_cnt;
    logic [STAT_W-1:0]    stall_lsb_cnt;
`endif

    modport slave (
`ifdef DISPATCH_STATS_EN
        output stall_rob_cnt, stall_rs_cnt, stall_lsb_cnt,
`endif
        input  rdy, rollback,
        input  iq_valid, iq_pc, dec_op, dec_rd, dec_imm, dec_rs1, dec_rs2, dec_is_ls,
        output iq_pop,
        input  rf_Vj, rf_Qj, rf_Vk, rf_Qk,
        input  rob_full, rob_tail, rs_full, lsb_full,
        input  alu_broadcast, alu_entry, alu_result,
        input  lsb_broadcast, lsb_entry, lsb_result,
        input  rob_commit, rob_entry, rob_result,
        output rs_get_instruction, lsb_get_instruction, rob_alloc, rename_en,
        output pc_out, op_out, rd_out, imm_out, entry_out,
        output Vj_out, Qj_out, Vk_out, Qk_out
    );

    modport master (
`ifdef DISPATCH_STATS_EN
        input  stall_rob_cnt, stall_rs_cnt, stall_lsb_cnt,
`endif
        output rdy, rollback,
        output iq_valid, iq_pc, dec_op, dec_rd, dec_imm, dec_rs1, dec_rs2, dec_is_ls,
        input  iq_pop,
        output rf_Vj, rf_Qj, rf_Vk, rf_Qk,
        output rob_full, rob_tail, rs_full, lsb_full,
        output alu_broadcast, alu_entry, alu_result,
        output lsb_broadcast, lsb_entry, lsb_result,
        output rob_commit, rob_entry, rob_result,
        input  rs_get_instruction, lsb_get_instruction, rob_alloc, rename_en,
        input  pc_out, op_out, rd_out, imm_out, entry_out,
        input  Vj_out, Qj_out, Vk_out, Qk_out
    );

endinterface

// File: rtl/dispatch_stage_operand_resolve.sv
// dispatch_operand_resolve: combinational snoop of one operand against the ALU
// CDB, LSB CDB and commit bus (priority alu > lsb > commit).
//   opnd          in   operand value / pending tag
//   alu/lsb/cmt   in   the three result buses
//   opnd_c        out  resolved operand (tag cleared, value replaced on a hit)
module dispatch_operand_resolve
    import dispatch_stage_pkg::*;
(
    input  operand_t opnd,
    input  cdb_t     alu,
    input  cdb_t     lsb,
    input  cdb_t     cmt,
    output operand_t opnd_c
);

    // A ready operand (ENTRY_NULL tag) never matches any bus.
    always_comb begin
        opnd_c = opnd;
        if (opnd.q != ENTRY_NULL) begin
            if (alu.valid && alu.entry == opnd.q) begin
                opnd_c = '{v: alu.result, q: ENTRY_NULL};
            end else if (lsb.valid && lsb.entry == opnd.q) begin
                opnd_c = '{v: lsb.result, q: ENTRY_NULL};
            end else if (cmt.valid && cmt.entry == opnd.q) begin
                opnd_c = '{v: cmt.result, q: ENTRY_NULL};
            end
        end
    end

endmodule

// File: rtl/dispatch_stage.sv
// dispatch_stage: single-slot issue stage between decoder and back end.
// Captures one decoded instruction, allocates the ROB tail entry, resolves
// operands (regfile, rename bypass, CDB/commit snoop) and issues to RS or LSB.
//   clk, rst    clock, synchronous active-low reset
//   bus         dispatch_stage_if.slave (decoder, regfile, ROB, RS/LSB, CDBs, issue bus)
// Optional macro DISPATCH_STATS_EN adds saturating stall counters
// stall_rob_cnt / stall_rs_cnt / stall_lsb_cnt on the interface.
module dispatch_stage
    import dispatch_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    dispatch_stage_if.slave        bus
);

    slot_state_e state_q, state_d;
    slot_t       slot_q;
    operand_t    opj_q, opk_q;

    cdb_t        alu_cdb, lsb_cdb, cmt_cdb;
    logic        held, blocked, issue_ok, pop;
    logic        byp_j, byp_k;
    operand_t    cap_j_pre, cap_k_pre, cap_j_res, cap_k_res, cap_j, cap_k;
    operand_t    out_j, out_k;

    assign alu_cdb = '{valid: bus.alu_broadcast, entry: bus.alu_entry, result: bus.alu_result};
    assign lsb_cdb = '{valid: bus.lsb_broadcast, entry: bus.lsb_entry, result: bus.lsb_result};
    assign cmt_cdb = '{valid: bus.rob_commit,    entry: bus.rob_entry, result: bus.rob_result};

    // Issue / capture qualification; reset suppresses every pulse.
    assign held     = (state_q == HELD);
    assign blocked  = bus.rob_full | (slot_q.is_ls ? bus.lsb_full : bus.rs_full);
    assign issue_ok = rst & held & bus.rdy & ~bus.rollback & ~blocked;
    assign pop      = rst & bus.iq_valid & bus.rdy & ~bus.rollback & (~held | issue_ok);

    // Slot state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and issue pulses.
    always_comb begin
        state_d                 = state_q;
        bus.iq_pop              = FALSE;
        bus.rs_get_instruction  = FALSE;
        bus.lsb_get_instruction = FALSE;
        bus.rob_alloc           = FALSE;
        bus.rename_en           = FALSE;

        if (issue_ok) begin
            bus.rs_get_instruction  = ~slot_q.is_ls;
            bus.lsb_get_instruction = slot_q.is_ls;
            bus.rob_alloc           = TRUE;
            bus.rename_en           = (slot_q.rd != '0);
        end
        bus.iq_pop = pop;

        if (bus.rdy) begin
            if (bus.rollback) begin
                state_d = EMPTY;
            end else if (pop) begin
                state_d = HELD;
            end else if (issue_ok) begin
                state_d = EMPTY;
            end
        end
    end

    // Rename bypass: the instruction leaving this cycle is not yet visible in the regfile.
    assign byp_j = issue_ok && (slot_q.rd != '0) && (RD_W'(bus.dec_rs1) == slot_q.rd);
    assign byp_k = issue_ok && (slot_q.rd != '0) && (RD_W'(bus.dec_rs2) == slot_q.rd);

    always_comb begin
        cap_j_pre = '{v: bus.rf_Vj, q: bus.rf_Qj};
        cap_k_pre = '{v: bus.rf_Vk, q: bus.rf_Qk};
        if (byp_j) cap_j_pre.q = slot_q.entry;
        if (byp_k) cap_k_pre.q = slot_q.entry;
    end

    dispatch_operand_resolve u_cap_j (
        .opnd(cap_j_pre), .alu(alu_cdb), .lsb(lsb_cdb), .cmt(cmt_cdb), .opnd_c(cap_j_res)
    );
    dispatch_operand_resolve u_cap_k (
        .opnd(cap_k_pre), .alu(alu_cdb), .lsb(lsb_cdb), .cmt(cmt_cdb), .opnd_c(cap_k_res)
    );

    // x0 is always ready and zero, regardless of what the regfile reports.
    always_comb begin
        cap_j = cap_j_res;
        cap_k = cap_k_res;
        if (bus.dec_rs1 == '0) cap_j = '{v: '0, q: ENTRY_NULL};
        if (bus.dec_rs2 == '0) cap_k = '{v: '0, q: ENTRY_NULL};
    end

    // Output-side snoop: the RS does not watch the entry it is latching.
    dispatch_operand_resolve u_out_j (
        .opnd(opj_q), .alu(alu_cdb), .lsb(lsb_cdb), .cmt(cmt_cdb), .opnd_c(out_j)
    );
    dispatch_operand_resolve u_out_k (
        .opnd(opk_q), .alu(alu_cdb), .lsb(lsb_cdb), .cmt(cmt_cdb), .opnd_c(out_k)
    );

    // Slot payload: load on pop, otherwise fold in snooped results while waiting.
    always_ff @(posedge clk) begin
        if (!rst) begin
            slot_q <= '{pc: '0, op: '0, rd: '0, imm: '0, is_ls: 1'b0, entry: ENTRY_NULL};
            opj_q  <= '{v: '0, q: ENTRY_NULL};
            opk_q  <= '{v: '0, q: ENTRY_NULL};
        end else if (pop) begin
            slot_q <= '{pc: bus.iq_pc, op: bus.dec_op, rd: bus.dec_rd, imm: bus.dec_imm,
                        is_ls: bus.dec_is_ls, entry: bus.rob_tail};
            opj_q  <= cap_j;
            opk_q  <= cap_k;
        end else if (held && bus.rdy && !bus.rollback && !issue_ok) begin
            opj_q  <= out_j;
            opk_q  <= out_k;
        end
    end

    assign bus.pc_out    = slot_q.pc;
    assign bus.op_out    = slot_q.op;
    assign bus.rd_out    = slot_q.rd;
    assign bus.imm_out   = slot_q.imm;
    assign bus.entry_out = slot_q.entry;
    assign bus.Vj_out    = out_j.v;
    assign bus.Qj_out    = out_j.q;
    assign bus.Vk_out    = out_k.v;
    assign bus.Qk_out    = out_k.q;

`ifdef DISPATCH_STATS_EN
    logic [STAT_W-1:0] stall_rob_q, stall_rs_q, stall_lsb_q;

    // One count per blocked HELD cycle; a full ROB is charged before RS/LSB.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_rob_q <= '0;
            stall_rs_q  <= '0;
            stall_lsb_q <= '0;
        end else if (held && bus.rdy) begin
            if (bus.rob_full) begin
                if (stall_rob_q != '1) stall_rob_q <= stall_rob_q + STAT_W'(1);
            end else if (slot_q.is_ls) begin
                if (bus.lsb_full && stall_lsb_q != '1) stall_lsb_q <= stall_lsb_q + STAT_W'(1);
            end else begin
                if (bus.rs_full && stall_rs_q != '1) stall_rs_q <= stall_rs_q + STAT_W'(1);
            end
        end
    end

    assign bus.stall_rob_cnt = stall_rob_q;
    assign bus.stall_rs_cnt  = stall_rs_q;
    assign bus.stall_lsb_cnt = stall_lsb_q;
`endif

endmodule

// File: tb/tb_dispatch_stage.sv
// tb_dispatch_stage: directed scenarios plus randomized traffic for dispatch_stage,
// checked every cycle against a transaction-level model of the issue slot.
module tb_dispatch_stage;

    localparam logic [5:0] NULLE = 6'b100000;

    logic clk;
    logic rst;

    dispatch_stage_if bus ();

    dispatch_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] v;
        logic [5:0]  q;
    } opnd_t;

    int n_vec;
    int n_err;

    // Model of the slot: whether an instruction is waiting, and what it carries.
    bit          m_held;
    logic [31:0] m_pc, m_imm;
    logic [5:0]  m_op, m_rd, m_entry;
    bit          m_ls;
    opnd_t       m_j, m_k;

    // First bus in priority order whose tag equals the operand's pending tag wins.
    function automatic opnd_t snoop(opnd_t o);
        logic        b[3];
        logic [5:0]  e[3];
        logic [31:0] r[3];
        b[0] = bus.alu_broadcast; e[0] = bus.alu_entry; r[0] = bus.alu_result;
        b[1] = bus.lsb_broadcast; e[1] = bus.lsb_entry; r[1] = bus.lsb_result;
        b[2] = bus.rob_commit;    e[2] = bus.rob_entry; r[2] = bus.rob_result;
        if (o.q == NULLE) return o;
        for (int i = 0; i < 3; i++) begin
            if (b[i] && e[i] == o.q) return '{r[i], NULLE};
        end
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare this cycle's outputs with the model, then advance the model.
    task automatic eval();
        bit    issue, pop, byp_j, byp_k;
        opnd_t pj, pk;
        #3;
        issue = rst && m_held && bus.rdy && !bus.rollback && !bus.rob_full &&
                !(m_ls ? bus.lsb_full : bus.rs_full);
        pop   = rst && bus.iq_valid && bus.rdy && !bus.rollback && (!m_held || issue);

        chk("iq_pop",    32'(bus.iq_pop),              32'(pop));
        chk("rs_get",    32'(bus.rs_get_instruction),  32'(issue && !m_ls));
        chk("lsb_get",   32'(bus.lsb_get_instruction), 32'(issue && m_ls));
        chk("rob_alloc", 32'(bus.rob_alloc),           32'(issue));
        chk("rename_en", 32'(bus.rename_en),           32'(issue && m_rd != 0));
        if (m_held) begin
            pj = snoop(m_j);
            pk = snoop(m_k);
            chk("pc_out",    bus.pc_out,         m_pc);
            chk("op_out",    32'(bus.op_out),    32'(m_op));
            chk("rd_out",    32'(bus.rd_out),    32'(m_rd));
            chk("imm_out",   bus.imm_out,        m_imm);
            chk("entry_out", 32'(bus.entry_out), 32'(m_entry));
            chk("Vj_out",    bus.Vj_out,         pj.v);
            chk("Qj_out",    32'(bus.Qj_out),    32'(pj.q));
            chk("Vk_out",    bus.Vk_out,         pk.v);
            chk("Qk_out",    32'(bus.Qk_out),    32'(pk.q));
        end

        if (!rst) begin
            m_held = 0;
        end else if (bus.rdy) begin
            if (bus.rollback) begin
                m_held = 0;
            end else if (pop) begin
                byp_j = issue && m_rd != 0 && m_rd == {1'b0, bus.dec_rs1};
                byp_k = issue && m_rd != 0 && m_rd == {1'b0, bus.dec_rs2};
                pj = (bus.dec_rs1 == 0) ? '{32'd0, NULLE}
                                        : snoop('{bus.rf_Vj, byp_j ? m_entry : bus.rf_Qj});
                pk = (bus.dec_rs2 == 0) ? '{32'd0, NULLE}
                                        : snoop('{bus.rf_Vk, byp_k ? m_entry : bus.rf_Qk});
                m_j = pj; m_k = pk;
                m_pc = bus.iq_pc; m_op = bus.dec_op; m_rd = bus.dec_rd; m_imm = bus.dec_imm;
                m_ls = bus.dec_is_ls; m_entry = bus.rob_tail;
                m_held = 1;
            end else if (issue) begin
                m_held = 0;
            end else if (m_held) begin
                m_j = snoop(m_j);
                m_k = snoop(m_k);
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rdy = 1; bus.rollback = 0;
        bus.iq_valid = 0; bus.iq_pc = 0; bus.dec_op = 0; bus.dec_rd = 0; bus.dec_imm = 0;
        bus.dec_rs1 = 0; bus.dec_rs2 = 0; bus.dec_is_ls = 0;
        bus.rf_Vj = 0; bus.rf_Qj = NULLE; bus.rf_Vk = 0; bus.rf_Qk = NULLE;
        bus.rob_full = 0; bus.rob_tail = 0; bus.rs_full = 0; bus.lsb_full = 0;
        bus.alu_broadcast = 0; bus.alu_entry = 0; bus.alu_result = 0;
        bus.lsb_broadcast = 0; bus.lsb_entry = 0; bus.lsb_result = 0;
        bus.rob_commit = 0; bus.rob_entry = 0; bus.rob_result = 0;
    endtask

    task automatic instr(input logic [5:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input bit ls, input logic [5:0] tail);
        bus.iq_valid = 1; bus.iq_pc = 32'h1000 + 32'(tail) * 4; bus.dec_op = 6'(tail + 1);
        bus.dec_rd = rd; bus.dec_rs1 = rs1; bus.dec_rs2 = rs2; bus.dec_is_ls = ls;
        bus.dec_imm = 32'h100 + 32'(tail); bus.rob_tail = tail;
    endtask

    function automatic logic [5:0] rnd_tag(input logic [5:0] pref);
        case ($urandom_range(0, 3))
            0:       return NULLE;
            1:       return (pref == NULLE) ? 6'($urandom_range(0, 31)) : pref;
            default: return 6'($urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        n_vec = 0; n_err = 0; m_held = 0;
        rst = 0;
        idle();
        @(posedge clk); #1;
        eval(); adv();
        eval();
        chk("rst_Qj_out",    32'(bus.Qj_out),    32'(NULLE));
        chk("rst_Qk_out",    32'(bus.Qk_out),    32'(NULLE));
        chk("rst_entry_out", 32'(bus.entry_out), 32'(NULLE));
        chk("rst_pc_out",    bus.pc_out,         32'd0);
        chk("rst_Vj_out",    bus.Vj_out,         32'd0);
        adv();
        rst = 1;
        eval(); adv();

        // Basic issue: ADD x3,x1,x2 into ROB entry 5.
        instr(6'd3, 5'd1, 5'd2, 0, 6'd5);
        eval(); chk("basic_pop", 32'(bus.iq_pop), 32'd1); adv();
        bus.iq_valid = 0;
        eval();
        chk("basic_rs_get", 32'(bus.rs_get_instruction), 32'd1);
        chk("basic_entry",  32'(bus.entry_out),          32'd5);
        chk("basic_rename", 32'(bus.rename_en),          32'd1);
        chk("basic_rd",     32'(bus.rd_out),             32'd3);
        adv();

        // Back-to-back dependency through the rename bypass.
        instr(6'd7, 5'd1, 5'd2, 0, 6'd4);
        eval(); adv();
        instr(6'd8, 5'd7, 5'd0, 0, 6'd6);
        eval(); adv();
        bus.iq_valid = 0;
        eval();
        chk("dep_Qj_out",    32'(bus.Qj_out),    32'd4);
        chk("dep_entry_out", 32'(bus.entry_out), 32'd6);
        adv();

        // Issue-cycle snoop on the output operand.
        instr(6'd9, 5'd0, 5'd5, 0, 6'd10);
        bus.rf_Qk = 6'd9;
        eval(); adv();
        bus.iq_valid = 0; bus.rf_Qk = NULLE;
        bus.alu_broadcast = 1; bus.alu_entry = 6'd9; bus.alu_result = 32'hDEAD;
        eval();
        chk("snoop_Qk_out", 32'(bus.Qk_out), 32'(NULLE));
        chk("snoop_Vk_out", bus.Vk_out,      32'hDEAD);
        adv();
        bus.alu_broadcast = 0;

        // RS full stall, then an LSB instruction bypasses the full RS.
        instr(6'd1, 5'd1, 5'd1, 0, 6'd11);
        bus.rs_full = 1;
        eval(); adv();
        instr(6'd2, 5'd2, 5'd2, 0, 6'd12);
        for (int i = 0; i < 3; i++) begin
            eval();
            chk("stall_rs_get", 32'(bus.rs_get_instruction), 32'd0);
            chk("stall_pop",    32'(bus.iq_pop),             32'd0);
            adv();
        end
        bus.rs_full = 0; bus.iq_valid = 0;
        eval(); adv();
        bus.rs_full = 1;
        instr(6'd2, 5'd3, 5'd4, 1, 6'd12);
        eval(); adv();
        bus.iq_valid = 0;
        eval();
        chk("stall_lsb_get", 32'(bus.lsb_get_instruction), 32'd1);
        chk("stall_rs_idle", 32'(bus.rs_get_instruction),  32'd0);
        adv();
        bus.rs_full = 0;

        // Rollback wins over issue and pop.
        instr(6'd5, 5'd1, 5'd2, 0, 6'd13);
        eval(); adv();
        bus.rollback = 1;
        eval();
        chk("rb_rs_get", 32'(bus.rs_get_instruction), 32'd0);
        chk("rb_pop",    32'(bus.iq_pop),             32'd0);
        chk("rb_alloc",  32'(bus.rob_alloc),          32'd0);
        adv();
        bus.rollback = 0; bus.rs_full = 1;
        eval(); chk("rb_pop_after", 32'(bus.iq_pop), 32'd1); adv();
        bus.rs_full = 0; bus.iq_valid = 0;
        eval(); adv();

        // Commit snoop while the ROB is full.
        instr(6'd6, 5'd4, 5'd0, 0, 6'd14);
        bus.rf_Qj = 6'd2; bus.rob_full = 1;
        eval(); adv();
        bus.iq_valid = 0; bus.rf_Qj = NULLE;
        bus.rob_commit = 1; bus.rob_entry = 6'd2; bus.rob_result = 32'h10;
        eval(); chk("cs_alloc_stall", 32'(bus.rob_alloc), 32'd0); adv();
        bus.rob_commit = 0; bus.rob_full = 0;
        eval();
        chk("cs_Qj_out", 32'(bus.Qj_out), 32'(NULLE));
        chk("cs_Vj_out", bus.Vj_out,      32'h10);
        chk("cs_alloc",  32'(bus.rob_alloc), 32'd1);
        adv();

        // Randomized traffic against the model.
        idle();
        repeat (3000) begin
            bus.rdy       = ($urandom_range(0, 9) != 0);
            bus.rollback  = ($urandom_range(0, 19) == 0);
            bus.iq_valid  = ($urandom_range(0, 9) < 7);
            bus.iq_pc     = $urandom;
            bus.dec_op    = 6'($urandom);
            bus.dec_rd    = 6'($urandom_range(0, 31));
            bus.dec_imm   = $urandom;
            bus.dec_rs1   = ($urandom_range(0, 3) == 0) ? m_rd[4:0] : 5'($urandom);
            bus.dec_rs2   = ($urandom_range(0, 3) == 0) ? m_rd[4:0] : 5'($urandom);
            bus.dec_is_ls = $urandom_range(0, 1) == 1;
            bus.rf_Vj     = $urandom;
            bus.rf_Qj     = rnd_tag(NULLE);
            bus.rf_Vk     = $urandom;
            bus.rf_Qk     = rnd_tag(NULLE);
            bus.rob_full  = ($urandom_range(0, 4) == 0);
            bus.rs_full   = ($urandom_range(0, 4) == 0);
            bus.lsb_full  = ($urandom_range(0, 4) == 0);
            bus.rob_tail  = 6'($urandom_range(0, 31));
            bus.alu_broadcast = $urandom_range(0, 2) == 0;
            bus.alu_entry     = rnd_tag(m_j.q) & 6'h1f;
            bus.alu_result    = $urandom;
            bus.lsb_broadcast = $urandom_range(0, 2) == 0;
            bus.lsb_entry     = rnd_tag(m_k.q) & 6'h1f;
            bus.lsb_result    = $urandom;
            bus.rob_commit    = $urandom_range(0, 2) == 0;
            bus.rob_entry     = rnd_tag(m_j.q) & 6'h1f;
            bus.rob_result    = $urandom;
            eval();
            adv();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dispatch_stage.md
Name: dispatch_stage

Overview:
- Single-slot issue stage between the instruction queue/decoder and the back end (reservation station, load/store buffer, ROB, regfile).
- Captures one decoded instruction per cycle, allocates the ROB tail entry, and resolves operands using the regfile, a rename bypass and same-cycle CDB/commit snooping.
- Issues to either the RS or the LSB with a one-cycle `get_instruction` pulse and renames rd in the regfile.
- Sustains one instruction per cycle when no downstream structure is full.

Parameters:
- ROB_W, 6, width of `ROBENTRY`; `ENTRY_NULL` = 6'b100000 (ROB index 0..31, NULL distinct).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low (reset when rst==0 at posedge clk).
- rdy  in  1  global pause; 0 freezes all state, no pulses issued.
- rollback  in  1  mispredict flush.
- iq_valid / iq_pc  in  1/32  decoded instruction present / its PC.
- dec_op / dec_rd / dec_imm  in  6/6/32  decoder op, destination (0 = none), immediate.
- dec_rs1 / dec_rs2  in  5/5  source registers (also drive regfile read ports externally).
- dec_is_ls  in  1  1 = load/store (routes to LSB).
- iq_pop  out  1  instruction consumed this cycle.
- rf_Vj / rf_Qj / rf_Vk / rf_Qk  in  32/6/32/6  regfile combinational read of dec_rs1/dec_rs2.
- rob_full / rob_tail  in  1/6  ROB full flag / next free entry.
- rs_full / lsb_full  in  1/1  RS and LSB full flags.
- alu_broadcast / alu_entry / alu_result  in  1/6/32  ALU CDB.
- lsb_broadcast / lsb_entry / lsb_result  in  1/6/32  LSB CDB.
- rob_commit / rob_entry / rob_result  in  1/6/32  commit bus.
- rs_get_instruction / lsb_get_instruction  out  1/1  issue pulses.
- rob_alloc / rename_en  out  1/1  ROB allocate pulse / regfile rename write (rd_out to entry_out).
- pc_out / op_out / rd_out / imm_out / entry_out  out  32/6/6/32/6  issue bus.
- Vj_out / Qj_out / Vk_out / Qk_out  out  32/6/32/6  resolved operands.

Behaviour:
- **Slot states.** EMPTY and HELD. `issue_ok` = HELD & rdy & !rollback & !rob_full & !(is_ls ? lsb_full : rs_full).
- **Issue cycle** (`issue_ok`):
  - Exactly one of rs_get_instruction / lsb_get_instruction is 1.
  - rob_alloc=1.
  - rename_en = (rd_out != 0).
  - Slot goes to EMPTY unless refilled the same cycle.
- **Capture.** iq_pop = iq_valid & rdy & !rollback & (EMPTY | issue_ok). On pop, the slot latches pc, op, rd, imm, is_ls, entry = rob_tail, Vj/Qj/Vk/Qk, and goes to HELD.
- **Rename bypass at capture.** If issue_ok and held rd != 0 and dec_rs1 == held rd, captured Qj = held entry_out (likewise for rs2/Qk). This overrides rf_*.
- **Snoop at capture.** If rf_Qj (or bypassed Qj) equals a broadcasting alu_entry, lsb_entry or rob_entry, latch Q=`ENTRY_NULL` and V=that result. Priority order: alu > lsb > commit.
- **Snoop while HELD.** Every cycle while HELD, apply the same snoop to the stored Qj/Qk (registered).
- **Issue-cycle snoop (output).** Vj_out/Qj_out and Vk_out/Qk_out are driven combinationally: the registered value, with the same-cycle snoop applied. This is required because the RS does not snoop the entry it is latching.
- **Zero register.** rs1==0 forces Vj=0, Qj=`ENTRY_NULL` (same for rs2).
- **Stalls.** Full flags hold the slot with no pulses; the slot contents stay stable except for snoop updates.
- **Rollback.** The slot goes to EMPTY; no pulse and no pop that cycle; rollback takes precedence over issue.
- **rdy=0.** Full freeze.
- **Reset values.**
  - All pulses 0, slot EMPTY.
  - Qj_out/Qk_out/entry_out = `ENTRY_NULL`.
  - Other bus outputs 0.

Optional Feature:
- Macro DISPATCH_STATS_EN.
- When defined: adds outputs stall_rob_cnt, stall_rs_cnt, stall_lsb_cnt (32-bit each, saturating). Each increments once per HELD & rdy cycle blocked by that cause; if several causes apply, the ROB cause takes priority. Counters are cleared by reset, not by rollback.
- When undefined: the ports and counters are absent, with no other change.

Decomposition:
- Shared package/defines holds `ROBENTRY`, `ENTRY_NULL`, `EMPTY`/`HELD` state encodings, and `TRUE`/`FALSE`.
- One natural sub-module: dispatch_operand_resolve. It is combinational: given Q/V plus the three broadcast buses it returns the resolved Q/V. It is instantiated four times (capture rs1/rs2, output rs1/rs2).

Test Plan:
- **Basic issue.** rst low 2 cycles, then ADD x3,x1,x2 with rf_Q* = NULL, rob_tail=5.
  - Cycle+1: rs_get_instruction=1, entry_out=5, rename_en=1, rd_out=3.
- **Back-to-back dependency.** Instr A rd=x7, rob_tail=4, then instr B rs1=x7.
  - B's Qj_out = 4 although rf_Qj = NULL.
- **Issue-cycle snoop.** Held Qk=9; alu_broadcast entry 9 result 0xDEAD in the issue cycle.
  - Qk_out = NULL, Vk_out = 0xDEAD in that same cycle.
- **Stall.** rs_full=1 for 3 cycles: no pulses, iq_pop=0. Then lsb instruction with lsb_full=0 and rs_full=1 while EMPTY: issues to the LSB.
- **Rollback.** Rollback while HELD and issue_ok: no pulses; next cycle the slot is EMPTY and iq_pop follows iq_valid.
- **Commit snoop during stall.** rob_full held while a commit of entry 2 with result 0x10 matches Qj=2: after release, Qj_out=NULL and Vj_out=0x10.
